// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply / divide unit. Multiply is shift-add and divide is
//   restoring division, both on operand magnitudes, followed by one cycle of
//   sign correction. The operation takes WIDTH+2 cycles from the edge that
//   accepts start to the done pulse. A divide by zero skips iteration and
//   raises done + div_zero one cycle after that edge, leaving hi/lo untouched.
//
//   Configuration macro: MULT_DIV_UNSIGNED_EN
//     defined   : op 10 = multu, op 11 = divu (no sign correction)
//     undefined : op[1] ignored, 10 behaves as 00 and 11 as 01
//
//   Ports
//     clock    in   rising-edge clock
//     reset    in   synchronous active-high reset
//     start    in   operation request, sampled only while idle
//     op       in   00 mult, 01 div, 10 multu, 11 divu
//     a        in   multiplicand / dividend
//     b        in   multiplier / divisor
//     busy     out  accepted operation in progress (includes its done cycle)
//     done     out  one-cycle pulse, hi/lo hold the new result
//     hi       out  upper product / remainder
//     lo       out  lower product / quotient
//     div_zero out  pulses with done when a division had b == 0
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Two's complement negation helpers
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + ONE_2W;
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   acc_r;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     mcand_r;    // multiplicand or divisor magnitude
    logic                 is_div_r;
    logic                 neg_main_r; // negate product / quotient
    logic                 neg_rem_r;  // negate remainder
    logic                 busy_r;
    logic                 done_r;
    logic                 div_zero_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 op_signed_s;
    logic                 op_div_s;
    logic                 b_zero_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic [WIDTH:0]       mult_sum_s;
    logic [2*WIDTH-1:0]   mult_next_s;
    logic [WIDTH:0]       div_val_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     div_diff_s;
    logic [2*WIDTH-1:0]   div_next_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     fix_hi_s;
    logic [WIDTH-1:0]     fix_lo_s;
    logic                 busy_s;
    logic                 done_s;
    logic                 div_zero_s;

`ifdef MULT_DIV_UNSIGNED_EN
    assign op_signed_s = ~op[1];
`else
    // op[1] has no meaning without the unsigned operations
    logic unused_op_s;
    assign unused_op_s = op[1];
    assign op_signed_s = 1'b1;
`endif

    assign op_div_s = op[0];
    assign b_zero_s = (b == {WIDTH{1'b0}});

    // Operand magnitudes taken at the accepting edge
    always_comb begin
        mag_a_s = a;
        mag_b_s = b;
        if (op_signed_s && a[WIDTH-1]) begin
            mag_a_s = neg_w(a);
        end else begin
            mag_a_s = a;
        end
        if (op_signed_s && b[WIDTH-1]) begin
            mag_b_s = neg_w(b);
        end else begin
            mag_b_s = b;
        end
    end

    // One shift-add step and one restoring-division step
    always_comb begin
        mult_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc_r[0] ? mcand_r : {WIDTH{1'b0}})};
        mult_next_s = {mult_sum_s, acc_r[WIDTH-1:1]};
        div_val_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_ge_s    = (div_val_s >= {1'b0, mcand_r});
        // Low bits of the difference are exact whenever the subtraction is taken
        div_diff_s  = div_val_s[WIDTH-1:0] - mcand_r;
        if (div_ge_s) begin
            div_next_s = {div_diff_s, acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_val_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction applied while in FIX
    always_comb begin
        prod_fix_s = neg_main_r ? neg_2w(acc_r) : acc_r;
        if (is_div_r) begin
            fix_hi_s = neg_rem_r  ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
            fix_lo_s = neg_main_r ? neg_w(acc_r[WIDTH-1:0])       : acc_r[WIDTH-1:0];
        end else begin
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (op_div_s) begin
                        state_s = b_zero_s ? DONE : DIV;
                    end else begin
                        state_s = MULT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MULT, DIV: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = FIX;
                end else begin
                    state_s = state_r;
                end
            end
            FIX:     state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM output logic: next values of the registered status outputs
    always_comb begin
        busy_s     = (state_s != IDLE);
        done_s     = (state_s == DONE);
        div_zero_s = (state_r == IDLE) && start && op_div_s && b_zero_s;
    end

    // Datapath, counter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r      <= {CW{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            mcand_r    <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            neg_main_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            busy_r     <= busy_s;
            done_r     <= done_s;
            div_zero_r <= div_zero_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cnt_r      <= CNT_LOAD;
                        is_div_r   <= op_div_s;
                        mcand_r    <= op_div_s ? mag_b_s : mag_a_s;
                        acc_r      <= {{WIDTH{1'b0}}, (op_div_s ? mag_a_s : mag_b_s)};
                        neg_main_r <= op_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_r  <= op_signed_s & a[WIDTH-1];
                    end
                end
                MULT: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    acc_r <= mult_next_s;
                end
                DIV: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    acc_r <= div_next_s;
                end
                FIX: begin
                    // Result becomes visible in the DONE cycle
                    hi_r <= fix_hi_s;
                    lo_r <= fix_lo_s;
                end
                DONE: begin
                    cnt_r <= {CW{1'b0}};
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed bench for mult_div_unit (WIDTH=32). A cycle-level reference model
//   computes results with native 64-bit arithmetic and tracks when busy/done
//   must appear; one negedge process compares every output each cycle. Directed
//   cases also check hand-computed literals and the start-to-done latency.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          div_zero;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference result: {div_by_zero, hi, lo}
    function automatic logic [64:0] ref_fn(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic        sgn;
        logic [63:0] p;
        longint      sx, sy, q, r;
        logic [63:0] qu, ru;
`ifdef MULT_DIV_UNSIGNED_EN
        sgn = ~o[1];
`else
        sgn = 1'b1;
`endif
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o[0] == 1'b0) begin
            if (sgn) p = sx * sy;
            else     p = {32'd0, x} * {32'd0, y};
            return {1'b0, p};
        end
        if (y == 32'd0) return {1'b1, 64'd0};
        if (sgn) begin
            q = sx / sy;
            r = sx % sy;
            qu = q;
            ru = r;
        end else begin
            qu = {32'd0, x} / {32'd0, y};
            ru = {32'd0, x} % {32'd0, y};
        end
        return {1'b0, ru[31:0], qu[31:0]};
    endfunction

    logic [64:0] ref_s;
    always_comb ref_s = ref_fn(op, a, b);

    // Reference model state
    bit          m_live = 1'b0;
    logic        m_busy, m_done, m_dz;
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    int          m_cnt;

    // Model: busy from the accepting edge, done WIDTH+1 edges later (or at once on /0)
    always @(posedge clock) begin
        if (reset) begin
            m_live <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_cnt  <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_hi   <= p_hi;
                m_lo   <= p_lo;
            end
        end else if (start) begin
            m_busy <= 1'b1;
            p_hi   <= ref_s[63:32];
            p_lo   <= ref_s[31:0];
            if (ref_s[64]) begin
                m_done <= 1'b1;
                m_dz   <= 1'b1;
            end else begin
                m_cnt <= W + 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
        if (m_live) begin
            chk("busy",     {63'd0, busy},     {63'd0, m_busy});
            chk("done",     {63'd0, done},     {63'd0, m_done});
            chk("div_zero", {63'd0, div_zero}, {63'd0, m_dz});
            chk("hi",       {32'd0, hi},       {32'd0, m_hi});
            chk("lo",       {32'd0, lo},       {32'd0, m_lo});
        end
    end

    // Issue one operation from a negedge; returns at the negedge where done is seen
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0; op = ~o; a = ~x; b = ~y;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clock);
            lat = lat + 1;
        end
    endtask

    task automatic check_op(input string nm, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] eh, input logic [W-1:0] el, input int elat, input logic edz);
        int lat;
        run_op(o, x, y, lat);
        chk({nm, "_lat"}, 64'(lat), 64'(elat));
        chk({nm, "_hi"},  {32'd0, hi}, {32'd0, eh});
        chk({nm, "_lo"},  {32'd0, lo}, {32'd0, el});
        chk({nm, "_dz"},  {63'd0, div_zero}, {63'd0, edz});
        @(negedge clock);
    endtask

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_hi",   {32'd0, hi}, 64'd0);
        chk("rst_lo",   {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);

        check_op("mul_7_m3",  2'b00, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 1'b0);
        check_op("div_m7_2",  2'b01, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0);
        check_op("div_5_0",   2'b01, 32'd5,          32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1,  1'b1);
        check_op("div_min_m1",2'b01, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 1'b0);
        check_op("mul_min2",  2'b00, 32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 34, 1'b0);
        check_op("div_7_m2",  2'b01, 32'd7,          32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, 1'b0);
        check_op("div_m7_m2", 2'b01, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 34, 1'b0);
        check_op("mul_big",   2'b00, 32'h12345678,   32'h00000010, 32'h00000001, 32'h23456780, 34, 1'b0);
        check_op("div_100_7", 2'b01, 32'd100,        32'd7,        32'h00000002, 32'h0000000E, 34, 1'b0);
`ifdef MULT_DIV_UNSIGNED_EN
        check_op("divu_op11", 2'b11, 32'hFFFFFFF9,   32'd2,        32'h00000001, 32'h7FFFFFFC, 34, 1'b0);
`else
        check_op("divu_op11", 2'b11, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0);
`endif

        // mult 3*4 with a second start while busy: must be dropped
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
        @(posedge clock);
        @(negedge clock);
        d0 = done_cnt;
        for (int i = 1; i <= 40; i++) begin
            if (i == 10) begin
                start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        chk("busy_start_pulses", 64'(done_cnt - d0), 64'd1);
        chk("busy_start_hi", {32'd0, hi}, 64'd0);
        chk("busy_start_lo", {32'd0, lo}, 64'd12);
        chk("busy_start_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of a divide aborts it
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        d0 = done_cnt;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
`ifdef MULT_DIV_UNSIGNED_EN
        check_op("multu_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 1'b0);
`else
        check_op("multu_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 34, 1'b0);
`endif
        // Start right after reset release
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_op("post_rst", 2'b00, 32'd5, 32'd6, 32'h00000000, 32'h0000001E, 34, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high, with ports named clock and reset.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the operand width; legal values are 4..64.
REQ-003 Port clock: input, 1 bit, rising-edge clock for all state.
REQ-004 Port reset: input, 1 bit, synchronous active-high reset.
REQ-005 Port start: input, 1 bit, operation request; sampled only in IDLE.
REQ-006 Port op: input, 2 bits, operation select: 00 mult, 01 div, 10 multu, 11 divu.
REQ-007 Port a: input, WIDTH bits, multiplicand or dividend.
REQ-008 Port b: input, WIDTH bits, multiplier or divisor.
REQ-009 Port busy: output, 1 bit, high while an accepted operation is in progress, including its done cycle.
REQ-010 Port done: output, 1 bit, one-cycle pulse marking the cycle in which hi and lo hold the new result.
REQ-011 Port hi: output, WIDTH bits, upper product or remainder.
REQ-012 Port lo: output, WIDTH bits, lower product or quotient.
REQ-013 Port div_zero: output, 1 bit, high together with done when a division had b == 0.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, MULT, DIV, FIX, DONE.
REQ-015 In IDLE with start=1, the block SHALL latch a, b and op in the same edge and go to MULT or DIV; the operand inputs are ignored afterwards.
REQ-016 MULT and DIV SHALL each run exactly WIDTH iteration cycles, counted by an internal counter of $clog2(WIDTH+1) bits that decrements to 0.
- MULT: shift-add on operand magnitudes.
- DIV: restoring division on operand magnitudes.
REQ-017 FIX SHALL apply sign correction in one cycle; DONE SHALL then update hi and lo, pulse done, and return to IDLE on the next edge.
REQ-018 Latency: done SHALL go high exactly WIDTH+2 cycles after the start-sampling edge (34 for WIDTH=32).
REQ-019 Multiplication SHALL produce the full 2*WIDTH-bit product, with {hi,lo} = a*b.
REQ-020 Signed division SHALL truncate toward zero.
- lo = quotient.
- hi = remainder, carrying the sign of the dividend.
REQ-021 Signed most-negative / -1 SHALL give lo = most-negative value (wrap), hi = 0, and no flag.
REQ-022 Division with b == 0 SHALL skip iteration.
- done and div_zero SHALL pulse exactly 1 cycle after the start-sampling edge.
- hi and lo SHALL remain unchanged.
REQ-023 A start asserted while busy=1 SHALL be ignored and never queued.
REQ-024 hi and lo SHALL hold their value between operations, and SHALL change only in DONE or on reset.
REQ-025 div_zero SHALL be low in every cycle where done is low.

Reset
REQ-026 While reset is high, the block SHALL force state=IDLE, counter=0, busy=0, done=0, div_zero=0, hi=0, lo=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse; a start is accepted on the first edge after reset deasserts.

Configuration
REQ-028 Macro MULT_DIV_UNSIGNED_EN SHALL control the unsigned operations.
- Defined: op 10 and 11 perform unsigned multiply and divide, with no sign correction in FIX.
- Undefined: op[1] is ignored, so 10 behaves as 00 and 11 as 01, and the unsigned datapath is not synthesised.

Verification (WIDTH=32)
REQ-029 mult, a=7, b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 34 cycles after start.
REQ-030 div, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-031 div, a=5, b=0 -> done=1 and div_zero=1 one cycle after start; hi/lo keep their prior values.
REQ-032 div, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 mult 3*4, then a second start at cycle 10 with different operands -> second start ignored; hi=0, lo=12; a single done pulse.
REQ-034 Reset at cycle 15 of a div -> no done; hi=lo=0; a following multu 0xFFFFFFFF*0xFFFFFFFF (with MULT_DIV_UNSIGNED_EN) -> hi=0xFFFFFFFE, lo=0x00000001.
